// File: rtl/tpu_pkg.sv
// Shared types and legal configuration ranges for the convolution window streamer.
// The start-time configuration check is kept here so every user applies the same rules.
package tpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } stream_state_t;

  typedef struct packed {
    logic [15:0] width;
    logic [15:0] height;
    logic [1:0]  stride;
    logic [1:0]  pad;
  } cfg_t;

  localparam logic [1:0] STRIDE_MIN = 2'd1;
  localparam logic [1:0] STRIDE_MAX = 2'd3;
  localparam logic [1:0] PAD_MAX    = 2'd2;

  // A map is rejected when the kernel cannot fit or the map overflows the buffer.
  function automatic logic cfg_invalid(input cfg_t cfg, input int unsigned k,
                                       input int unsigned ch, input int unsigned depth);
    logic [17:0] span_w;
    logic [17:0] span_h;
    logic [63:0] elems;
    span_w = {2'b00, cfg.width}  + {15'd0, cfg.pad, 1'b0};
    span_h = {2'b00, cfg.height} + {15'd0, cfg.pad, 1'b0};
    elems  = 64'(cfg.width) * 64'(cfg.height) * 64'(ch);
    return (cfg.stride < STRIDE_MIN) || (cfg.pad > PAD_MAX) ||
           (span_w < 18'(k)) || (span_h < 18'(k)) || (elems > 64'(depth));
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Walks window origins row by row and produces the buffer address and in-bounds flag
// of every window element. Origins are tracked directly so no divider is needed.
module window_addr_gen
  import tpu_pkg::*;
#(
  parameter int numInChannel = 1,
  parameter int kernelWidth  = 3,
  localparam int nPEy        = kernelWidth * kernelWidth * numInChannel
) (
  input  logic                   clk,
  input  logic                   rst,
  input  cfg_t                   cfg,
  input  logic                   init,
  input  logic                   advance,
  output logic [nPEy-1:0][31:0]  elem_addr,
  output logic [nPEy-1:0]        elem_inb,
  output logic                   is_last
);

  localparam logic signed [18:0] K_S = 19'(kernelWidth);

  logic signed [16:0] oy_r;
  logic signed [16:0] ox_r;
  logic signed [16:0] pad_neg_s;
  logic signed [16:0] stride_s;
  logic signed [18:0] x_end_s;
  logic signed [18:0] y_end_s;
  logic signed [18:0] x_lim_s;
  logic signed [18:0] y_lim_s;
  logic               col_last_s;
  logic               row_last_s;

  assign pad_neg_s = 17'sd0 - $signed({15'd0, cfg.pad});
  assign stride_s  = $signed({15'd0, cfg.stride});

  // The next origin is illegal once its far edge passes the padded border.
  assign x_end_s = {{2{ox_r[16]}}, ox_r} + {{2{stride_s[16]}}, stride_s} + K_S;
  assign y_end_s = {{2{oy_r[16]}}, oy_r} + {{2{stride_s[16]}}, stride_s} + K_S;
  assign x_lim_s = $signed({3'd0, cfg.width})  + $signed({17'd0, cfg.pad});
  assign y_lim_s = $signed({3'd0, cfg.height}) + $signed({17'd0, cfg.pad});

  assign col_last_s = (x_end_s > x_lim_s);
  assign row_last_s = (y_end_s > y_lim_s);
  assign is_last    = col_last_s && row_last_s;

  // Origin counters: x inner, y outer, both starting at -pad.
  always_ff @(posedge clk) begin
    if (rst) begin
      oy_r <= 17'sd0;
      ox_r <= 17'sd0;
    end else if (init) begin
      oy_r <= pad_neg_s;
      ox_r <= pad_neg_s;
    end else if (advance) begin
      if (col_last_s) begin
        ox_r <= pad_neg_s;
        oy_r <= oy_r + stride_s;
      end else begin
        ox_r <= ox_r + stride_s;
      end
    end
  end

  for (genvar gi = 0; gi < nPEy; gi++) begin : g_elem
    localparam int KY = gi / (kernelWidth * numInChannel);
    localparam int KX = (gi / numInChannel) % kernelWidth;
    localparam int CH = gi % numInChannel;

    logic signed [16:0] r_s;
    logic signed [16:0] c_s;

    assign r_s = oy_r + 17'(KY);
    assign c_s = ox_r + 17'(KX);
    assign elem_inb[gi] = !r_s[16] && !c_s[16] &&
                          (r_s[15:0] < cfg.height) && (c_s[15:0] < cfg.width);
    assign elem_addr[gi] = ((32'(r_s[15:0]) * 32'(cfg.width)) + 32'(c_s[15:0])) *
                           32'(numInChannel) + 32'(CH);
  end

endmodule

// File: rtl/conv_window_streamer.sv
// Buffers one multi-channel feature map and streams one im2col window per output pixel
// with configurable stride and zero padding over a valid/ready handshake.
module conv_window_streamer
  import tpu_pkg::*;
#(
  parameter int dataSize      = 8,
  parameter int numInChannel  = 1,
  parameter int kernelWidth   = 3,
  parameter int numRegister   = 256,
  localparam int nPEy          = kernelWidth * kernelWidth * numInChannel,
  localparam int numAddrBuffer = $clog2(numRegister)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [numAddrBuffer-1:0]       wr_addr,
  input  logic [dataSize-1:0]            wr_data,
  input  logic [15:0]                    cfg_ifmap_width,
  input  logic [15:0]                    cfg_ifmap_height,
  input  logic [1:0]                     cfg_stride,
  input  logic [1:0]                     cfg_pad,
  input  logic                           ctrl_start,
  output logic [nPEy-1:0][dataSize-1:0]  win_data,
  output logic                           win_valid,
  input  logic                           win_ready,
  output logic                           win_last,
  output logic                           flag_busy,
  output logic                           flag_done,
  output logic                           flag_err
);

  localparam logic [31:0] DEPTH = 32'(numRegister);

  logic [dataSize-1:0]           mem_r [numRegister];
  stream_state_t                 state_r;
  cfg_t                          cfg_r;
  cfg_t                          cfg_in_s;
  cfg_t                          cfg_gen_s;
  logic                          pend_r;
  logic                          idle_like_s;
  logic                          start_err_s;
  logic                          start_ok_s;
  logic                          load_s;
  logic                          xfer_s;
  logic [nPEy-1:0][31:0]         elem_addr_s;
  logic [nPEy-1:0]               elem_inb_s;
  logic                          is_last_s;
  logic [nPEy-1:0][dataSize-1:0] gather_s;

  assign cfg_in_s    = '{width: cfg_ifmap_width, height: cfg_ifmap_height,
                         stride: cfg_stride, pad: cfg_pad};
  assign idle_like_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
  assign start_err_s = cfg_invalid(cfg_in_s, kernelWidth, numInChannel, numRegister);
  assign start_ok_s  = idle_like_s && ctrl_start && !start_err_s;
  // The generator must see the incoming pad on the start edge itself.
  assign cfg_gen_s   = start_ok_s ? cfg_in_s : cfg_r;
  assign xfer_s      = win_valid && win_ready;
  assign load_s      = (state_r == ST_RUN) && pend_r && (!win_valid || win_ready);

  window_addr_gen #(
    .numInChannel (numInChannel),
    .kernelWidth  (kernelWidth)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .cfg       (cfg_gen_s),
    .init      (start_ok_s),
    .advance   (load_s),
    .elem_addr (elem_addr_s),
    .elem_inb  (elem_inb_s),
    .is_last   (is_last_s)
  );

  // Feature map storage; survives reset and is frozen while streaming.
  always_ff @(posedge clk) begin
    if (wr_en && idle_like_s && (32'(wr_addr) < DEPTH)) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Window gather: padding and out-of-range elements read as zero.
  always_comb begin
    gather_s = '0;
    for (int i = 0; i < nPEy; i++) begin
      if (elem_inb_s[i] && (elem_addr_s[i] < DEPTH)) begin
        gather_s[i] = mem_r[elem_addr_s[i][numAddrBuffer-1:0]];
      end else begin
        gather_s[i] = '0;
      end
    end
  end

  // Control FSM with registered window and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cfg_r     <= '0;
      pend_r    <= 1'b0;
      win_data  <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      flag_busy <= 1'b0;
      flag_done <= 1'b0;
      flag_err  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (ctrl_start) begin
            cfg_r     <= cfg_in_s;
            flag_err  <= start_err_s;
            flag_done <= start_err_s;
            flag_busy <= !start_err_s;
            pend_r    <= !start_err_s;
            state_r   <= start_err_s ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (xfer_s && win_last) begin
            state_r   <= ST_DONE;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            flag_busy <= 1'b0;
            flag_done <= 1'b1;
          end else if (load_s) begin
            win_data  <= gather_s;
            win_valid <= 1'b1;
            win_last  <= is_last_s;
            if (is_last_s) begin
              pend_r <= 1'b0;
            end
          end else if (xfer_s) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          pend_r    <= 1'b0;
          win_valid <= 1'b0;
          win_last  <= 1'b0;
          flag_busy <= 1'b0;
          flag_done <= 1'b0;
          flag_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_streamer.sv
// Scoreboard bench: expected windows come from a direct arithmetic im2col model of the
// buffered map; a negedge monitor pops and compares every transferred window.
module tb_conv_window_streamer;

  localparam int DS   = 8;
  localparam int C    = 1;
  localparam int K    = 3;
  localparam int NREG = 256;
  localparam int NPE  = K * K * C;
  localparam int AW   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DS-1:0]     wr_data;
  logic [15:0]       cfg_ifmap_width;
  logic [15:0]       cfg_ifmap_height;
  logic [1:0]        cfg_stride;
  logic [1:0]        cfg_pad;
  logic              ctrl_start;
  logic [NPE*DS-1:0] win_data;
  logic              win_valid;
  logic              win_ready;
  logic              win_last;
  logic              flag_busy;
  logic              flag_done;
  logic              flag_err;

  typedef struct {
    logic [NPE*DS-1:0] data;
    logic              last;
  } exp_t;

  exp_t              exp_q[$];
  logic [DS-1:0]     mdl_mem [NREG];
  int                checks = 0;
  int                failures = 0;
  int                xfer_cnt = 0;

  always #5 clk = ~clk;

  conv_window_streamer #(
    .dataSize     (DS),
    .numInChannel (C),
    .kernelWidth  (K),
    .numRegister  (NREG)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .cfg_ifmap_width  (cfg_ifmap_width),
    .cfg_ifmap_height (cfg_ifmap_height),
    .cfg_stride       (cfg_stride),
    .cfg_pad          (cfg_pad),
    .ctrl_start       (ctrl_start),
    .win_data         (win_data),
    .win_valid        (win_valid),
    .win_ready        (win_ready),
    .win_last         (win_last),
    .flag_busy        (flag_busy),
    .flag_done        (flag_done),
    .flag_err         (flag_err)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return ((k % 4) == 0) || ((k % 4) == 3);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = DS'(d);
    tick();
    wr_en = 1'b0;
    mdl_mem[a] = DS'(d);
  endtask

  // Monitor: compares each transfer with the scoreboard and checks stall stability.
  initial begin : monitor
    logic              hold_v;
    logic [NPE*DS-1:0] hold_d;
    logic              hold_l;
    exp_t              e;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("stall_valid", win_valid, 1'b1);
          chk("stall_data", {win_last, win_data}, {hold_l, hold_d});
        end
        if (win_valid && win_ready) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_window actual=%0h expected=none", win_data);
          end else begin
            e = exp_q.pop_front();
            chk("win_data", win_data, e.data);
            chk("win_last", win_last, e.last);
          end
        end
        hold_v = win_valid && !win_ready;
        hold_d = win_data;
        hold_l = win_last;
      end
    end
  end

  task automatic run(input int w, input int h, input int s, input int p,
                     input int rmode, input int wr_run, input int rst_after);
    int   ow, oh, total, k, r, c;
    bit   err;
    exp_t e;
    err   = (s == 0) || (p > 2) || (w + 2*p < K) || (h + 2*p < K) || (w*h*C > NREG);
    total = 0;
    if (!err) begin
      ow    = (w + 2*p - K) / s + 1;
      oh    = (h + 2*p - K) / s + 1;
      total = ow * oh;
      for (int oy = 0; oy < oh; oy++) begin
        for (int ox = 0; ox < ow; ox++) begin
          e.data = '0;
          for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx < K; kx++) begin
              for (int ch = 0; ch < C; ch++) begin
                r = oy*s - p + ky;
                c = ox*s - p + kx;
                if (r >= 0 && r < h && c >= 0 && c < w)
                  e.data[((ky*K + kx)*C + ch)*DS +: DS] = mdl_mem[(r*w + c)*C + ch];
              end
            end
          end
          e.last = (oy == oh-1) && (ox == ow-1);
          exp_q.push_back(e);
        end
      end
    end
    xfer_cnt         = 0;
    cfg_ifmap_width  = 16'(w);
    cfg_ifmap_height = 16'(h);
    cfg_stride       = 2'(s);
    cfg_pad          = 2'(p);
    ctrl_start       = 1'b1;
    win_ready        = 1'b0;
    tick();
    ctrl_start = 1'b0;
    if (err) begin
      chk("err_flag", flag_err, 1'b1);
      chk("err_done", flag_done, 1'b1);
      chk("err_valid", win_valid, 1'b0);
      chk("err_busy", flag_busy, 1'b0);
      win_ready = 1'b1;
      repeat (3) tick();
      chk("err_no_valid", win_valid, 1'b0);
      win_ready = 1'b0;
      return;
    end
    chk("start_latency", win_valid, 1'b0);
    k = 0;
    win_ready = rdy(rmode, 0);
    while (1) begin
      tick();
      k++;
      if (k == 1) begin
        chk("first_valid", win_valid, 1'b1);
        chk("busy", flag_busy, 1'b1);
        chk("done_clr", flag_done, 1'b0);
        chk("err_clr", flag_err, 1'b0);
      end
      if (rst_after > 0 && xfer_cnt >= rst_after) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_flags", {win_valid, win_last, flag_busy, flag_done, flag_err}, 5'd0);
        chk("rst_data", win_data, '0);
        exp_q.delete();
        win_ready = 1'b0;
        return;
      end
      if (flag_done) break;
      if (k > 3000) begin
        checks++;
        failures++;
        $display("FAIL run_timeout actual=%0d expected=%0d", xfer_cnt, total);
        break;
      end
      if (wr_run != 0 && k == 2) begin
        wr_en   = 1'b1;
        wr_addr = AW'(6);
        wr_data = 8'hAA;
      end else begin
        wr_en = 1'b0;
      end
      win_ready = rdy(rmode, k);
    end
    wr_en = 1'b0;
    if (rmode == 0) chk("throughput_cycles", k, total + 1);
    chk("xfers", xfer_cnt, total);
    chk("queue_empty", exp_q.size(), 0);
    chk("end_busy", flag_busy, 1'b0);
    chk("end_valid", win_valid, 1'b0);
    chk("end_err", flag_err, 1'b0);
    win_ready = 1'b0;
  endtask

  initial begin
    int w, h;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    cfg_ifmap_width = 16'd0;
    cfg_ifmap_height = 16'd0;
    cfg_stride = 2'd0;
    cfg_pad = 2'd0;
    ctrl_start = 1'b0;
    win_ready = 1'b0;
    tick();
    tick();
    chk("reset_flags", {win_valid, win_last, flag_busy, flag_done, flag_err}, 5'd0);
    chk("reset_data", win_data, '0);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) wr(i, i);
    run(5, 5, 1, 0, 0, 0, 0);
    run(5, 5, 2, 0, 0, 0, 0);
    run(5, 5, 1, 1, 0, 0, 0);
    run(5, 5, 1, 0, 1, 0, 0);
    run(2, 2, 1, 0, 0, 0, 0);
    run(5, 5, 0, 0, 0, 0, 0);
    run(5, 5, 1, 0, 0, 1, 0);
    run(5, 5, 1, 0, 0, 0, 0);
    run(5, 5, 1, 0, 0, 0, 4);
    run(5, 5, 1, 0, 0, 0, 0);
    run(20, 20, 1, 0, 0, 0, 0);

    for (int i = 0; i < 256; i++) wr(i, $urandom_range(0, 255));
    run(16, 16, 3, 2, 2, 0, 0);

    for (int it = 0; it < 8; it++) begin
      w = $urandom_range(1, 12);
      h = $urandom_range(1, 12);
      for (int i = 0; i < w*h; i++) wr(i, $urandom_range(0, 255));
      run(w, h, $urandom_range(1, 3), $urandom_range(0, 2), 2, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
